// File: rtl/demux_pkg.sv
// Shared encodings for the registered 1:2 demultiplexer and its output slots.
package demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register: load fills it, valid&&ready empties it; 1 cycle latency.
// Backpressure: while FULL and ready_i is low, data and valid hold; a load only arrives when it may.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DATAWIDTH-1:0] data_in_i,
  input  logic                 ready_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 valid_o
);

  slot_state_e          state_q;
  logic [DATAWIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else if (load_i) begin
      // Covers both EMPTY fill and FULL drain-with-reload.
      state_q <= SLOT_FULL;
      data_q  <= data_in_i;
    end else if (state_q == SLOT_FULL && ready_i) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux_1x2.sv
// Registered 1:2 demux, words appear on a/b one cycle after acceptance; a stalled output never blocks the other.
// Define DEMUX_RR_EN to ignore sel and alternate destinations a, b, a, ... from reset.
module demux_1x2
  import demux_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sel,
  output logic [DATAWIDTH-1:0] a,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [DATAWIDTH-1:0] b,
  output logic                 b_valid,
  input  logic                 b_ready
);

  logic dest;
  logic dest_valid;
  logic dest_ready;
  logic xfer;
  logic load_a;
  logic load_b;

`ifdef DEMUX_RR_EN
  logic rr_q;
  logic rr_d;
  logic unused_sel;

  assign unused_sel = sel;
  assign dest       = rr_q;
  // Pointer only advances on an accepted word, so a stalled dest is never skipped.
  assign rr_d       = xfer ? ~rr_q : rr_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rr_q <= SEL_A;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign dest = sel;
`endif

  assign dest_valid = (dest == SEL_B) ? b_valid : a_valid;
  assign dest_ready = (dest == SEL_B) ? b_ready : a_ready;
  assign in_ready   = !dest_valid || dest_ready;
  assign xfer       = in_valid && in_ready;
  assign load_a     = xfer && (dest == SEL_A);
  assign load_b     = xfer && (dest == SEL_B);

  demux_out_slot #(
    .DATAWIDTH(DATAWIDTH)
  ) u_slot_a (
    .clk_i    (Clk),
    .rst_ni   (Rst),
    .load_i   (load_a),
    .data_in_i(in_data),
    .ready_i  (a_ready),
    .data_o   (a),
    .valid_o  (a_valid)
  );

  demux_out_slot #(
    .DATAWIDTH(DATAWIDTH)
  ) u_slot_b (
    .clk_i    (Clk),
    .rst_ni   (Rst),
    .load_i   (load_b),
    .data_in_i(in_data),
    .ready_i  (b_ready),
    .data_o   (b),
    .valid_o  (b_valid)
  );

endmodule

// File: tb/tb_demux_1x2.sv
// Directed bench for demux_1x2: drives and samples on the falling edge, expectations hand-computed.
module tb_demux_1x2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       sel = 1'b0;
  logic [7:0] a;
  logic       a_valid;
  logic       a_ready = 1'b0;
  logic [7:0] b;
  logic       b_valid;
  logic       b_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  demux_1x2 #(.DATAWIDTH(8)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel     (sel),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready)
  );

  always #5 Clk = ~Clk;

  task automatic test_reset();
    Rst = 1'b0; in_valid = 1'b1; in_data = 8'hFF; sel = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL reset_a got=%h exp=00", a); end
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL reset_b got=%h exp=00", b); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_routing();
    @(negedge Clk);
    a_ready = 1'b1; b_ready = 1'b1;
    sel = 1'b0; in_data = 8'h11; in_valid = 1'b1;
    @(negedge Clk);
    checks++; if (a !== 8'h11 || a_valid !== 1'b1) begin errors++; $display("FAIL route_a got=%h/%b exp=11/1", a, a_valid); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL route_a_b_valid got=%b exp=0", b_valid); end
    sel = 1'b1; in_data = 8'h22;
    @(negedge Clk);
    checks++; if (b !== 8'h22 || b_valid !== 1'b1) begin errors++; $display("FAIL route_b got=%h/%b exp=22/1", b, b_valid); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL route_b_a_valid got=%b exp=0", a_valid); end
    in_valid = 1'b0;
    @(negedge Clk);
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL route_b_drain got=%b exp=0", b_valid); end
  endtask

  task automatic test_independent_stall();
    @(negedge Clk);
    a_ready = 1'b0; b_ready = 1'b1;
    sel = 1'b0; in_data = 8'h33; in_valid = 1'b1;
    @(negedge Clk);
    in_data = 8'h44;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    @(negedge Clk);
    checks++; if (a !== 8'h33 || a_valid !== 1'b1) begin errors++; $display("FAIL stall_a_hold got=%h/%b exp=33/1", a, a_valid); end
    sel = 1'b1; in_data = 8'h55;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_other_in_ready got=%b exp=1", in_ready); end
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (b !== 8'h55 || b_valid !== 1'b1) begin errors++; $display("FAIL stall_b got=%h/%b exp=55/1", b, b_valid); end
    checks++; if (a !== 8'h33 || a_valid !== 1'b1) begin errors++; $display("FAIL stall_a_still got=%h/%b exp=33/1", a, a_valid); end
    a_ready = 1'b1;
    @(negedge Clk);
    checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b%b exp=00", a_valid, b_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    @(negedge Clk);
    a_ready = 1'b1; b_ready = 1'b1; sel = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        exp = 8'(i);
        checks++;
        if (a !== exp || a_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_a[%0d] got=%h/%b exp=%h/1", i, a, a_valid, exp);
        end
      end
      if (i < 8) begin
        in_data = 8'(i + 1); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge Clk);
    end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", a_valid); end
  endtask

  task automatic test_midstream_reset();
    @(negedge Clk);
    a_ready = 1'b0; b_ready = 1'b0;
    sel = 1'b0; in_data = 8'h77; in_valid = 1'b1;
    @(negedge Clk);
    sel = 1'b1; in_data = 8'h88;
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (a !== 8'h77 || b !== 8'h88 || a_valid !== 1'b1 || b_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got=%h/%b %h/%b exp=77/1 88/1", a, a_valid, b, b_valid);
    end
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b%b exp=00", a_valid, b_valid); end
    checks++; if (a !== 8'h00 || b !== 8'h00) begin errors++; $display("FAIL mid_rst_data got=%h %h exp=00 00", a, b); end
  endtask

`ifdef DEMUX_RR_EN
  task automatic test_round_robin();
    logic [7:0] exp;
    @(negedge Clk);
    a_ready = 1'b1; b_ready = 1'b1; sel = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        exp = 8'hA0 + 8'(i - 1);
        checks++;
        if (i % 2 == 1) begin
          if (a !== exp || a_valid !== 1'b1 || b_valid !== 1'b0) begin
            errors++; $display("FAIL rr_a[%0d] got=%h/%b exp=%h/1", i, a, a_valid, exp);
          end
        end else begin
          if (b !== exp || b_valid !== 1'b1 || a_valid !== 1'b0) begin
            errors++; $display("FAIL rr_b[%0d] got=%h/%b exp=%h/1", i, b, b_valid, exp);
          end
        end
      end
      if (i < 4) begin in_data = 8'hA0 + 8'(i); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge Clk);
    end
    a_ready = 1'b0;
    in_data = 8'hA4; in_valid = 1'b1;
    @(negedge Clk);
    in_data = 8'hA5;
    @(negedge Clk);
    in_data = 8'hA6;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rr_stall_in_ready got=%b exp=0", in_ready); end
    @(negedge Clk);
    checks++; if (in_ready !== 1'b0 || a !== 8'hA4) begin errors++; $display("FAIL rr_stall_hold got=%b/%h exp=0/a4", in_ready, a); end
    a_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_release got=%b exp=1", in_ready); end
    @(negedge Clk);
    in_valid = 1'b0;
    checks++; if (a !== 8'hA6 || a_valid !== 1'b1) begin errors++; $display("FAIL rr_a6 got=%h/%b exp=a6/1", a, a_valid); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DEMUX_RR_EN
    test_round_robin();
`else
    test_routing();
    test_independent_stall();
    test_back_to_back();
    test_midstream_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1x2.md
# demux_1x2

Registered 1-to-2 demultiplexer with valid/ready handshaking. It is the steering counterpart of the 2:1 multiplexer in the datapath component library. A single input stream is routed to output `a` or output `b`, and each output is held in its own one-entry output register. The generated HLS datapaths use it wherever one producer feeds two consumers that may stall independently.

## Interface
Parameters:
- DATAWIDTH, 8, width of the data path in bits.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Rst  input  1  synchronous, active-low reset, sampled on the Clk rising edge.
- in_data  input  DATAWIDTH  input word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the block accepts in_data this cycle.
- sel  input  1  destination select: 0 = a, 1 = b. Ignored when DEMUX_RR_EN is defined.
- a  output  DATAWIDTH  output word for port a (registered).
- a_valid  output  1  a holds a word.
- a_ready  input  1  consumer of a accepts this cycle.
- b  output  DATAWIDTH  output word for port b (registered).
- b_valid  output  1  b holds a word.
- b_ready  input  1  consumer of b accepts this cycle.

## Operation
- Each output has a slot with two states: EMPTY and FULL.
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on drain without load (valid && ready).
  - FULL -> FULL on drain with a simultaneous load.
- dest = sel, or rr_ptr when DEMUX_RR_EN is defined.
- in_ready = !valid_dest || ready_dest.
  - This is a combinational path from a_ready/b_ready and sel to in_ready.
- An input transfer happens when in_valid && in_ready. The word is loaded into the dest slot only; the other slot is untouched.
- While a slot is FULL and its ready is low, its data and valid are held stable.
- A stalled output never blocks the other output. If sel points to the free output, in_ready is high.
- in_data and sel are don't-care when in_valid is low; no load occurs.
- Reset (Rst low at a clock edge):
  - a, b = 0.
  - a_valid, b_valid = 0.
  - rr_ptr = 0.
  - Reset asserted mid-stream discards any held words; no output handshake completes in that cycle.
- in_ready is 1 in the first cycle after reset.

## Timing
- Latency: a word accepted at edge N is visible on a/b with valid at edge N (registered output), i.e. the cycle after in_valid && in_ready was sampled.
- Throughput: one word per cycle total when the dest consumer keeps ready high.
- Back-to-back loads to the same FULL slot that is draining the same cycle are legal and lose no data.
- Simultaneous drain of a and b plus a load to either slot is legal in one cycle.
- No combinational path from in_data to a/b.

## Configuration
- Macro: DEMUX_RR_EN.
- Defined: sel is ignored.
  - rr_ptr (1 bit) picks dest and toggles on every accepted input transfer, so words alternate a, b, a, ... starting with a after reset.
  - If the dest slot is FULL and not draining, in_ready is low; the pointer does not skip ahead.
- Undefined: routing follows sel only; no rr_ptr register exists.

## Structure
- Shared package `demux_pkg`:
  - SEL_A = 1'b0, SEL_B = 1'b1.
  - Slot state encoding SLOT_EMPTY / SLOT_FULL.
- Sub-module `demux_out_slot`:
  - One-entry register with load/data_in/valid/ready.
  - Parameterised by DATAWIDTH and instantiated twice.
  - Top level contains only dest selection, in_ready, and rr_ptr.

## Test plan
- **Reset:**
  - Stimulus: hold Rst low for 2 cycles with in_valid=1, in_data=8'hFF.
  - Required: a=b=0, a_valid=b_valid=0, in_ready=1 after release.
- **Routing:**
  - Stimulus: sel=0 with data 8'h11, then sel=1 with data 8'h22, both readies high.
  - Required: a=8'h11 with a_valid for 1 cycle, then b=8'h22 with b_valid; the other output's valid stays 0.
- **Independent stall:**
  - Stimulus: a_ready=0 with a FULL (8'h33), then present sel=0 with 8'h44.
  - Required: in_ready=0, a holds 8'h33.
  - Stimulus: switch to sel=1 with 8'h55.
  - Required: in_ready=1, b=8'h55.
- **Simultaneous drain+load:**
  - Stimulus: stream 8'h01..8'h08 with sel=0 and a_ready=1 every cycle.
  - Required: a shows 8'h01..8'h08 on consecutive cycles with no bubble.
- **Mid-stream reset:**
  - Stimulus: a and b FULL with both readies low; pulse Rst low for 1 cycle.
  - Required: both valids 0 on the next cycle, held words lost.
- **DEMUX_RR_EN:**
  - Stimulus: with the macro defined, send 8'hA0..8'hA3 with sel tied to 1 and readies high.
  - Required: A0 -> a, A1 -> b, A2 -> a, A3 -> b.
  - Stimulus: stall a_ready when A2 is due.
  - Required: in_ready=0 until a drains.
